// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and constants for the unified RAM port controller:
//   FSM state encoding, requesting-port id, request length codes and
//   the RAM data bus width, plus a helper turning a length code into a
//   byte count.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_t;

    localparam logic [1:0] MEM_LEN_BYTE = 2'b00;
    localparam logic [1:0] MEM_LEN_HALF = 2'b01;
    localparam logic [1:0] MEM_LEN_WORD = 2'b10;

    localparam int RAM_DATA_W = 8;

    // Byte count for a length code; the reserved code 11 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            MEM_LEN_BYTE: n = 3'd1;
            MEM_LEN_HALF: n = 3'd2;
            default:      n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Shares one byte-wide RAM port between instruction fetch (IF) and data
//   access (MEM). Each 8/16/32-bit request is split into byte transfers,
//   little-endian. MEM has fixed priority over IF.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req_i / if_addr_i     word fetch request and byte address
//   if_data_o / if_done_o    fetched word, valid during the one-cycle done pulse
//   mem_req_i, mem_we_i      data request, 1=store 0=load
//   mem_len_i                00=byte 01=half 10/11=word
//   mem_addr_i, mem_wdata_i  data byte address and store data
//   mem_rdata_o / mem_done_o zero-extended load data and done pulse
//   stallreq_if_o/_mem_o     pipeline freeze requests (combinational)
//   ram_addr_o, ram_dout_o   RAM byte address and write byte
//   ram_wr_o                 1=write current byte
//   ram_din_i                RAM read byte, one cycle after its address
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate and latch the winning request
// RD    | issue byte addresses, collect bytes one cycle later
// WR    | issue one byte write per cycle
// DONE  | one-cycle done pulse with data, no arbitration
import mem_ctrl_pkg::*;

module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    state_t                 r_state;
    port_t                  r_port;
    logic [2:0]             r_n;
    logic [2:0]             r_cnt;
    logic [ADDR_W-1:0]      r_base;
    logic [31:0]            r_wdata;
    logic [31:0]            r_buf;
    logic [31:0]            r_if_data;
    logic                   r_if_done;
    logic [31:0]            r_mem_rdata;
    logic                   r_mem_done;
    logic [ADDR_W-1:0]      r_ram_addr;
    logic [RAM_DATA_W-1:0]  r_ram_dout;
    logic                   r_ram_wr;

    logic [31:0]            w_merged;
    logic [7:0]             w_wbyte_next;
    logic [ADDR_W-1:0]      w_next_addr;
    logic                   w_last_addr;
    logic                   w_unused;

    // Upper address bits are dropped: the RAM only decodes ADDR_W bits.
    assign w_unused = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    // Address of the byte after the current one; wraps modulo 2^ADDR_W.
    assign w_next_addr = r_base + ADDR_W'(r_cnt) + ADDR_W'(1);
    assign w_last_addr = ((r_cnt + 3'd1) == r_n);

    // Byte arriving now belongs to the address issued last cycle, lane cnt-1.
    always_comb begin
        w_merged = r_buf;
        case (r_cnt)
            3'd1:    w_merged[7:0]   = ram_din_i;
            3'd2:    w_merged[15:8]  = ram_din_i;
            3'd3:    w_merged[23:16] = ram_din_i;
            3'd4:    w_merged[31:24] = ram_din_i;
            default: w_merged        = r_buf;
        endcase
    end

    always_comb begin
        w_wbyte_next = 8'h00;
        case (r_cnt)
            3'd0:    w_wbyte_next = r_wdata[15:8];
            3'd1:    w_wbyte_next = r_wdata[23:16];
            3'd2:    w_wbyte_next = r_wdata[31:24];
            default: w_wbyte_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_port      <= PORT_IF;
            r_n         <= 3'd0;
            r_cnt       <= 3'd0;
            r_base      <= '0;
            r_wdata     <= 32'h0;
            r_buf       <= 32'h0;
            r_if_data   <= 32'h0;
            r_if_done   <= 1'b0;
            r_mem_rdata <= 32'h0;
            r_mem_done  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_dout  <= 8'h00;
            r_ram_wr    <= 1'b0;
        end else begin
            // Done and data are single-cycle; cleared unless set below.
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_data   <= 32'h0;
            r_mem_rdata <= 32'h0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 3'd0;
                    r_buf <= 32'h0;
                    if (mem_req_i) begin
                        r_port     <= PORT_MEM;
                        r_n        <= len_bytes(mem_len_i);
                        r_base     <= mem_addr_i[ADDR_W-1:0];
                        r_wdata    <= mem_wdata_i;
                        r_ram_addr <= mem_addr_i[ADDR_W-1:0];
                        if (mem_we_i) begin
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= mem_wdata_i[7:0];
                            r_state    <= ST_WR;
                        end else begin
                            r_state    <= ST_RD;
                        end
                    end else if (if_req_i) begin
                        r_port     <= PORT_IF;
                        r_n        <= 3'd4;
                        r_base     <= if_addr_i[ADDR_W-1:0];
                        r_wdata    <= 32'h0;
                        r_ram_addr <= if_addr_i[ADDR_W-1:0];
                        r_state    <= ST_RD;
                    end
                end

                ST_RD: begin
                    if (r_cnt != 3'd0) begin
                        r_buf <= w_merged;
                    end
                    if (r_cnt == r_n) begin
                        r_ram_addr <= '0;
                        r_state    <= ST_DONE;
                        if (r_port == PORT_IF) begin
                            r_if_done <= 1'b1;
                            r_if_data <= w_merged;
                        end else begin
                            r_mem_done  <= 1'b1;
                            r_mem_rdata <= w_merged;
                        end
                    end else begin
                        r_cnt      <= r_cnt + 3'd1;
                        // One idle address cycle while the last byte returns.
                        r_ram_addr <= w_last_addr ? '0 : w_next_addr;
                    end
                end

                ST_WR: begin
                    if (w_last_addr) begin
                        r_ram_addr <= '0;
                        r_ram_dout <= 8'h00;
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt      <= r_cnt + 3'd1;
                        r_ram_addr <= w_next_addr;
                        r_ram_dout <= w_wbyte_next;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_data_o      = r_if_data;
    assign if_done_o      = r_if_done;
    assign mem_rdata_o    = r_mem_rdata;
    assign mem_done_o     = r_mem_done;
    assign ram_addr_o     = r_ram_addr;
    assign ram_dout_o     = r_ram_dout;
    assign ram_wr_o       = r_ram_wr;
    assign stallreq_if_o  = if_req_i & ~r_if_done;
    assign stallreq_mem_o = mem_req_i & ~r_mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int AW = 17;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req_i = 1'b0;
    logic [31:0]   if_addr_i = 32'h0;
    logic [31:0]   if_data_o;
    logic          if_done_o;
    logic          mem_req_i = 1'b0;
    logic          mem_we_i = 1'b0;
    logic [1:0]    mem_len_i = 2'b00;
    logic [31:0]   mem_addr_i = 32'h0;
    logic [31:0]   mem_wdata_i = 32'h0;
    logic [31:0]   mem_rdata_o;
    logic          mem_done_o;
    logic          stallreq_if_o;
    logic          stallreq_mem_o;
    logic [AW-1:0] ram_addr_o;
    logic [7:0]    ram_dout_o;
    logic          ram_wr_o;
    logic [7:0]    ram_din_i = 8'h00;

    logic [7:0] ram_mem [0:MSZ-1];
    logic [7:0] ref_mem [0:MSZ-1];

    int n_pass = 0;
    int n_total = 0;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o),
        .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    // External byte RAM: one-cycle read latency, synchronous write.
    always @(posedge clk) begin
        if (ram_wr_o) ram_mem[ram_addr_o] <= ram_dout_o;
        ram_din_i <= ram_mem[ram_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [AW-1:0] a, input logic [7:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic chk_ram_idle(input string tag);
        chk({tag, " ram_addr"}, 32'(ram_addr_o), 32'h0);
        chk({tag, " ram_wr"},   32'(ram_wr_o),   32'h0);
        chk({tag, " ram_dout"}, 32'(ram_dout_o), 32'h0);
    endtask

    // One complete transfer starting in an IDLE cycle (cycle 0). Expected
    // address/data per cycle and completion cycle come from the byte model.
    task automatic xfer(input bit is_if, input bit we_in, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit scramble, output logic [31:0] got);
        int n;
        int done_cyc;
        bit we;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        logic [31:0] exp_data;
        logic [31:0] wd;
        we = is_if ? 1'b0 : we_in;
        n = is_if ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
        base = addr[AW-1:0];
        wd = wdata;
        exp_data = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            exp_data[8*i +: 8] = ref_mem[a];
        end
        done_cyc = we ? n + 1 : n + 2;
        got = 32'h0;
        if (is_if) begin
            if_req_i = 1'b1; if_addr_i = addr;
        end else begin
            mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len;
            mem_addr_i = addr; mem_wdata_i = wdata;
        end
        for (int c = 0; c <= done_cyc; c++) begin
            if (c > 0) tick();
            if (scramble && c == 2) begin
                if (is_if) if_addr_i = $urandom();
                else begin
                    mem_addr_i = $urandom(); mem_wdata_i = $urandom();
                    mem_len_i = 2'($urandom_range(0, 3));
                end
            end
            #1;
            if (c >= 1 && c <= n) begin
                a = base + AW'(c - 1);
                chk("xfer ram_addr", 32'(ram_addr_o), 32'(a));
                chk("xfer ram_wr", 32'(ram_wr_o), 32'(we));
                chk("xfer ram_dout", 32'(ram_dout_o), we ? 32'(wd[8*(c-1) +: 8]) : 32'h0);
            end else begin
                chk_ram_idle("xfer idle");
            end
            if (is_if) begin
                chk("if_done", 32'(if_done_o), 32'(c == done_cyc));
                chk("mem_done quiet", 32'(mem_done_o), 32'h0);
                chk("stallreq_if", 32'(stallreq_if_o), 32'(c != done_cyc));
                if (c == done_cyc) begin
                    got = if_data_o;
                    chk("if_data", if_data_o, exp_data);
                end
            end else begin
                chk("mem_done", 32'(mem_done_o), 32'(c == done_cyc));
                chk("if_done quiet", 32'(if_done_o), 32'h0);
                chk("stallreq_mem", 32'(stallreq_mem_o), 32'(c != done_cyc));
                if (c == done_cyc) begin
                    got = mem_rdata_o;
                    if (!we) chk("mem_rdata", mem_rdata_o, exp_data);
                end
            end
        end
        tick();
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                a = base + AW'(i);
                ref_mem[a] = wd[8*i +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] r;
        logic [AW-1:0] lo;

        for (int i = 0; i < MSZ; i++) begin
            ram_mem[i] = 8'($urandom());
            ref_mem[i] = ram_mem[i];
        end
        put_byte(17'h100, 8'h13); put_byte(17'h101, 8'h05);
        put_byte(17'h102, 8'h10); put_byte(17'h103, 8'h00);
        put_byte(17'h40, 8'h80);

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk_ram_idle("reset");
        chk("reset if_done", 32'(if_done_o), 32'h0);
        chk("reset mem_done", 32'(mem_done_o), 32'h0);
        chk("reset if_data", if_data_o, 32'h0);
        chk("reset mem_rdata", mem_rdata_o, 32'h0);
        rst = 1'b0;
        tick();

        // Word fetch at 0x100
        xfer(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, got);
        chk("fetch word 0x100", got, 32'h00100513);

        // Simultaneous requests: store byte wins, fetch follows
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b00;
        mem_addr_i = 32'h20; mem_wdata_i = 32'hAB;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            if (c == 3) mem_req_i = 1'b0;
            #1;
            if (c == 1) begin
                chk("simul wr", 32'(ram_wr_o), 32'h1);
                chk("simul wr addr", 32'(ram_addr_o), 32'h20);
                chk("simul wr dout", 32'(ram_dout_o), 32'hAB);
            end
            chk("simul mem_done", 32'(mem_done_o), 32'(c == 2));
            if (c >= 4 && c <= 7)
                chk("simul if addr", 32'(ram_addr_o), 32'h100 + 32'(c - 4));
            chk("simul if_done", 32'(if_done_o), 32'(c == 9));
            chk("simul stallreq_if", 32'(stallreq_if_o), 32'(c != 9));
            if (c == 9) chk("simul if_data", if_data_o, 32'h00100513);
        end
        tick();
        if_req_i = 1'b0;
        ref_mem[17'h20] = 8'hAB;

        // Half store across the top of the address space, then read back
        xfer(1'b0, 1'b1, 2'b01, 32'h0001FFFF, 32'h0000BEEF, 1'b0, got);
        xfer(1'b0, 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 1'b0, got);
        chk("sh wrap readback", got, 32'h0000BEEF);

        // Load byte 0x80, zero-extended
        xfer(1'b0, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, got);
        chk("lb 0x40", got, 32'h00000080);

        // Fetch with address changed mid-transfer
        xfer(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b1, got);
        chk("fetch ignores change", got, 32'h00100513);

        // Reset in cycle 3 of a fetch
        if_req_i = 1'b1; if_addr_i = 32'h100;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk_ram_idle("midrst");
        chk("midrst if_done", 32'(if_done_o), 32'h0);
        chk("midrst if_data", if_data_o, 32'h0);
        if_req_i = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post-rst no done", 32'(if_done_o), 32'h0);
        end
        xfer(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, got);
        chk("refetch after rst", got, 32'h00100513);

        // Randomized traffic in a small window spanning the wrap point
        for (int it = 0; it < 40; it++) begin
            r = $urandom();
            lo = 17'h1FFE0 + AW'($urandom_range(0, 63));
            xfer(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), {r[31:AW], lo}, $urandom(),
                 1'($urandom_range(0, 1)), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
